// File: rtl/aes128_pkg.sv
// Shared types, register map and decode helpers for the aes128 AFU.
// Everything here is used by the HardCloud CSR responder and the read/write engines.
package aes128_pkg;

  localparam int HC_BUFFER_SIZE = 3;
  localparam int HC_BUF_IDX_W   = $clog2(HC_BUFFER_SIZE);

  typedef logic [63:0] t_hc_address;
  typedef logic [31:0] t_hc_control;

  localparam t_hc_control HC_CONTROL_ASSERT_RST   = 32'h0;
  localparam t_hc_control HC_CONTROL_DEASSERT_RST = 32'h1;
  localparam t_hc_control HC_CONTROL_START        = 32'h3;

  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_FETCH = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRAIN = 3'd3,
    RD_DONE  = 3'd4
  } t_rd_state;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_WAIT  = 3'd1,
    WR_PUSH  = 3'd2,
    WR_FENCE = 3'd3,
    WR_DONE  = 3'd4
  } t_wr_state;

  typedef struct packed {
    logic [55:0] rsvd_hi;
    logic        done;
    t_rd_state   rd_state;
    logic        rsvd_lo;
    t_wr_state   wr_state;
  } t_hc_status;

  // Minimal CCI-P MMIO view: only the fields this AFU's CSR path consumes.
  localparam logic [1:0] CCIP_MMIO_LEN_4 = 2'h0;
  localparam logic [1:0] CCIP_MMIO_LEN_8 = 2'h1;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  // Byte offsets of the CSR map.
  localparam logic [15:0] AFU_DFH        = 16'h000;
  localparam logic [15:0] AFU_ID_L       = 16'h008;
  localparam logic [15:0] AFU_ID_H       = 16'h010;
  localparam logic [15:0] HC_DSM_BASE    = 16'h110;
  localparam logic [15:0] HC_CONTROL     = 16'h118;
  localparam logic [15:0] HC_BUFFER_BASE = 16'h120;
  localparam logic [15:0] HC_STATUS      = 16'h180;
  localparam logic [15:0] HC_CYCLES      = 16'h188;

  localparam logic [15:0] HC_BUFFER_BASE_DW = HC_BUFFER_BASE >> 2;

  // hdr.address counts DWORDs; compare against byte offsets without losing the top bits.
  function automatic logic hc_at(input logic [15:0] dw, input logic [15:0] byte_off);
    return {dw, 2'b00} == {2'b00, byte_off};
  endfunction

  function automatic logic hc_dsm_sel(input logic [15:0] dw);
    return hc_at(dw, HC_DSM_BASE);
  endfunction

  function automatic logic hc_control_sel(input logic [15:0] dw);
    return hc_at(dw, HC_CONTROL);
  endfunction

  // Each descriptor spans 16 bytes (4 DWORDs): address at +0, size at +8.
  function automatic logic hc_buffer_sel(input logic [15:0] dw);
    return (dw >= HC_BUFFER_BASE_DW) && !dw[0] &&
           (((dw - HC_BUFFER_BASE_DW) >> 2) < 16'(HC_BUFFER_SIZE));
  endfunction

  function automatic logic [HC_BUF_IDX_W-1:0] hc_buffer_which(input logic [15:0] dw);
    return HC_BUF_IDX_W'((dw - HC_BUFFER_BASE_DW) >> 2);
  endfunction

endpackage

// File: rtl/hc_cycle_counter.sv
// Free-running 64-bit cycle counter with enable and synchronous clear.
// Clear has priority over enable; the count wraps naturally at 2^64.
module hc_cycle_counter (
  input  logic        clk,
  input  logic        SoftReset_n,
  input  logic        en,
  input  logic        clr,
  output logic [63:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/hc_mmio_csr_responder.sv
// HardCloud CSR block: captures host MMIO writes into shadow registers and
// answers every MMIO read on c2 with a one-cycle registered response.
module hc_mmio_csr_responder
  import aes128_pkg::*;
#(
  parameter logic [127:0] AFU_ID    = 128'h0,
  parameter logic [63:0]  DFH_VALUE = 64'h1000_0100_0000_0000
) (
  input  logic           clk,
  input  logic           SoftReset_n,
  input  t_if_ccip_c0_Rx rx_mmio,
  output t_if_ccip_c2_Tx tx_mmio,
  output t_hc_address    hc_dsm_base,
  output t_hc_control    hc_control,
  output t_hc_buffer     hc_buffer [HC_BUFFER_SIZE],
  input  t_rd_state      rd_state,
  input  t_wr_state      wr_state,
  input  logic           done
);

  logic [63:0]             cycles;
  logic [15:0]             wr_dw;
  logic [HC_BUF_IDX_W-1:0] wr_idx;
  logic                    wr_ctl_clr;

  logic [15:0]             rd_dw;
  logic [HC_BUF_IDX_W-1:0] rd_idx;
  t_hc_status              status;
  logic [63:0]             rd_reg;
  logic [63:0]             rd_data;

  assign wr_dw  = rx_mmio.hdr.address;
  assign wr_idx = hc_buffer_which(wr_dw);
  // Clearing from the write itself lets a read in the very next cycle already see 0.
  assign wr_ctl_clr = rx_mmio.mmioWrValid && hc_control_sel(wr_dw) &&
                      (rx_mmio.data[31:0] == HC_CONTROL_ASSERT_RST);

  hc_cycle_counter u_cycle_counter (
    .clk        (clk),
    .SoftReset_n(SoftReset_n),
    .en         (hc_control == HC_CONTROL_START),
    .clr        (wr_ctl_clr),
    .count      (cycles)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_dw           = {rx_mmio.hdr.address[15:1], 1'b0};
    rd_idx          = hc_buffer_which(rd_dw);
    status          = '0;
    status.done     = done;
    status.rd_state = rd_state;
    status.wr_state = wr_state;
    rd_reg          = '0;
    if (hc_at(rd_dw, AFU_DFH))          rd_reg = DFH_VALUE;
    else if (hc_at(rd_dw, AFU_ID_L))    rd_reg = AFU_ID[63:0];
    else if (hc_at(rd_dw, AFU_ID_H))    rd_reg = AFU_ID[127:64];
    else if (hc_dsm_sel(rd_dw))         rd_reg = hc_dsm_base;
    else if (hc_control_sel(rd_dw))     rd_reg = {32'h0, hc_control};
    else if (hc_buffer_sel(rd_dw))      rd_reg = rd_dw[1] ? {32'h0, hc_buffer[rd_idx].size}
                                                          : hc_buffer[rd_idx].address;
    else if (hc_at(rd_dw, HC_STATUS))   rd_reg = status;
    else if (hc_at(rd_dw, HC_CYCLES))   rd_reg = cycles;

    rd_data = rd_reg;
    if (rx_mmio.hdr.length == CCIP_MMIO_LEN_4) begin
      rd_data = rx_mmio.hdr.address[0] ? {32'h0, rd_reg[63:32]} : {32'h0, rd_reg[31:0]};
    end
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      tx_mmio     <= '0;
      hc_dsm_base <= '0;
      hc_control  <= '0;
      // NOTE: the descriptor array is a handful of flops, not a RAM, so resetting it is cheap and safe.
      for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
        hc_buffer[i] <= '0;
      end
    end else begin
      tx_mmio.mmioRdValid <= 1'b0;
      if (rx_mmio.mmioWrValid) begin
        if (hc_dsm_sel(wr_dw)) begin
          hc_dsm_base <= rx_mmio.data;
        end else if (hc_control_sel(wr_dw)) begin
          hc_control <= rx_mmio.data[31:0];
        end else if (hc_buffer_sel(wr_dw)) begin
          if (wr_dw[1]) hc_buffer[wr_idx].size    <= rx_mmio.data[31:0];
          else          hc_buffer[wr_idx].address <= rx_mmio.data;
        end
      end else if (rx_mmio.mmioRdValid) begin
        tx_mmio.mmioRdValid <= 1'b1;
        tx_mmio.hdr.tid     <= rx_mmio.hdr.tid;
        tx_mmio.data        <= rd_data;
      end
    end
  end

  // A single c0 header cannot carry both a read and a write.
  a_no_rd_wr_collision: assert property (@(posedge clk) disable iff (!SoftReset_n)
    !(rx_mmio.mmioRdValid && rx_mmio.mmioWrValid));

endmodule

// File: tb/tb_hc_mmio_csr_responder.sv
// Directed bench for the HardCloud CSR responder: inputs change and outputs
// are sampled on the falling edge, expectations are hand-computed constants.
module tb_hc_mmio_csr_responder;
  import aes128_pkg::*;

  localparam logic [63:0] EXP_DFH = 64'h1000_0100_0000_0000;

  logic           clk;
  logic           SoftReset_n;
  t_if_ccip_c0_Rx rx_mmio;
  t_if_ccip_c2_Tx tx_mmio;
  t_hc_address    hc_dsm_base;
  t_hc_control    hc_control;
  t_hc_buffer     hc_buffer [HC_BUFFER_SIZE];
  t_rd_state      rd_state;
  t_wr_state      wr_state;
  logic           done;

  int n_tests = 0;
  int n_fail  = 0;

  hc_mmio_csr_responder dut (
    .clk        (clk),
    .SoftReset_n(SoftReset_n),
    .rx_mmio    (rx_mmio),
    .tx_mmio    (tx_mmio),
    .hc_dsm_base(hc_dsm_base),
    .hc_control (hc_control),
    .hc_buffer  (hc_buffer),
    .rd_state   (rd_state),
    .wr_state   (wr_state),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic wr(input logic [15:0] byte_off, input logic [63:0] d);
    rx_mmio                = '0;
    rx_mmio.hdr.address    = {2'b00, byte_off[15:2]};
    rx_mmio.hdr.length     = CCIP_MMIO_LEN_8;
    rx_mmio.data           = d;
    rx_mmio.mmioWrValid    = 1'b1;
    @(negedge clk);
    rx_mmio = '0;
  endtask

  task automatic rd_req(input logic [15:0] dw, input logic [1:0] len, input logic [8:0] tid);
    rx_mmio             = '0;
    rx_mmio.hdr.address = dw;
    rx_mmio.hdr.length  = len;
    rx_mmio.hdr.tid     = tid;
    rx_mmio.mmioRdValid = 1'b1;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] dw, input logic [1:0] len,
                          input logic [8:0] tid, input logic [63:0] exp_data);
    rd_req(dw, len, tid);
    @(negedge clk);
    rx_mmio = '0;
    check({tag, " valid"}, 64'(tx_mmio.mmioRdValid), 64'd1);
    check({tag, " tid"},   64'(tx_mmio.hdr.tid),     64'(tid));
    check({tag, " data"},  tx_mmio.data,             exp_data);
  endtask

  logic [15:0] b2b_dw   [5] = '{16'h0044, 16'h000C, 16'h004C, 16'h0006, 16'h0000};
  logic [63:0] b2b_data [5] = '{64'h1122_3344_5566_7788, 64'h0, 64'hDEAD_BEEF_0000_1000,
                                64'h0, EXP_DFH};

  initial begin
    rx_mmio     = '0;
    rd_state    = RD_IDLE;
    wr_state    = WR_IDLE;
    done        = 1'b0;
    SoftReset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset valid", 64'(tx_mmio.mmioRdValid), 64'd0);
    check("reset data",  tx_mmio.data,             64'd0);
    check("reset ctl",   64'(hc_control),          64'd0);
    SoftReset_n = 1'b1;
    @(negedge clk);

    rd_check("rst control", 16'h0046, CCIP_MMIO_LEN_8, 9'h001, 64'd0);
    rd_check("rst cycles",  16'h0062, CCIP_MMIO_LEN_8, 9'h002, 64'd0);

    rd_check("dfh", 16'h0000, CCIP_MMIO_LEN_8, 9'h02A, EXP_DFH);
    @(negedge clk);
    check("dfh single pulse", 64'(tx_mmio.mmioRdValid), 64'd0);
    rd_check("afu id lo", 16'h0002, CCIP_MMIO_LEN_8, 9'h003, 64'd0);
    rd_check("afu id hi", 16'h0004, CCIP_MMIO_LEN_8, 9'h004, 64'd0);

    // Descriptor 1 address, then its 32-bit size, then an out-of-range descriptor 3.
    wr(16'h0130, 64'hDEAD_BEEF_0000_1000);
    check("buf1 addr out", hc_buffer[1].address, 64'hDEAD_BEEF_0000_1000);
    rd_check("buf1 addr", 16'h004C, CCIP_MMIO_LEN_8, 9'h005, 64'hDEAD_BEEF_0000_1000);
    check("buf0 addr out", hc_buffer[0].address, 64'd0);
    wr(16'h0138, 64'hFFFF_FFFF_0000_0040);
    check("buf1 size out", 64'(hc_buffer[1].size), 64'h40);
    rd_check("buf1 size", 16'h004E, CCIP_MMIO_LEN_8, 9'h006, 64'h40);
    wr(16'h0150, 64'h0000_0000_0000_1234);
    rd_check("buf3 ignored", 16'h0054, CCIP_MMIO_LEN_8, 9'h007, 64'd0);
    check("buf2 addr out", hc_buffer[2].address, 64'd0);

    wr(16'h0110, 64'h1122_3344_5566_7788);
    check("dsm out", hc_dsm_base, 64'h1122_3344_5566_7788);
    rd_check("dsm 4B lo", 16'h0044, CCIP_MMIO_LEN_4, 9'h008, 64'h0000_0000_5566_7788);
    rd_check("dsm 4B hi", 16'h0045, CCIP_MMIO_LEN_4, 9'h009, 64'h0000_0000_1122_3344);
    rd_check("dsm 8B odd", 16'h0045, CCIP_MMIO_LEN_8, 9'h00A, 64'h1122_3344_5566_7788);

    // STATUS: done=1, rd_state=4, wr_state=3 -> 0x80 | 0x40 | 0x03.
    done     = 1'b1;
    rd_state = RD_DONE;
    wr_state = WR_FENCE;
    rd_check("status", 16'h0060, CCIP_MMIO_LEN_8, 9'h00B, 64'h0000_0000_0000_00C3);
    rd_check("status 4B hi", 16'h0061, CCIP_MMIO_LEN_4, 9'h00C, 64'd0);
    done = 1'b0;

    wr(16'h0118, 64'hAAAA_AAAA_0000_0001);
    check("ctl out", 64'(hc_control), 64'd1);
    rd_check("ctl low32", 16'h0046, CCIP_MMIO_LEN_8, 9'h00D, 64'd1);

    rd_req(b2b_dw[0], CCIP_MMIO_LEN_8, 9'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) rd_req(b2b_dw[k+1], CCIP_MMIO_LEN_8, 9'(k + 2));
      else       rx_mmio = '0;
      check($sformatf("b2b%0d valid", k), 64'(tx_mmio.mmioRdValid), 64'd1);
      check($sformatf("b2b%0d tid", k),   64'(tx_mmio.hdr.tid),     64'(k + 1));
      check($sformatf("b2b%0d data", k),  tx_mmio.data,             b2b_data[k]);
    end
    @(negedge clk);
    check("b2b idle", 64'(tx_mmio.mmioRdValid), 64'd0);

    // START is seen at 100 rising edges before the stop write takes effect.
    wr(16'h0118, 64'd3);
    repeat (99) @(negedge clk);
    wr(16'h0118, 64'd1);
    rd_check("cycles run", 16'h0062, CCIP_MMIO_LEN_8, 9'h010, 64'd100);
    rd_check("cycles hold", 16'h0062, CCIP_MMIO_LEN_8, 9'h011, 64'd100);
    wr(16'h0118, 64'd0);
    rd_check("cycles clr", 16'h0062, CCIP_MMIO_LEN_8, 9'h012, 64'd0);

    rd_req(16'h0000, CCIP_MMIO_LEN_8, 9'h013);
    #2 SoftReset_n = 1'b0;
    @(negedge clk);
    rx_mmio = '0;
    check("rst drop valid", 64'(tx_mmio.mmioRdValid), 64'd0);
    SoftReset_n = 1'b1;
    @(negedge clk);
    check("rst drop after", 64'(tx_mmio.mmioRdValid), 64'd0);
    check("rst buf1 out", hc_buffer[1].address, 64'd0);
    rd_check("rst dsm", 16'h0044, CCIP_MMIO_LEN_8, 9'h014, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
